// File: rtl/neo_pkg.sv
// Shared definitions for the NeoPixel frame arbiter.
//   - default strip geometry and arbitration limits
//   - color index constants (GREEN=0, RED=1, BLUE=2; index 3 is invalid)
//   - arbiter state encoding
package neo_pkg;

  localparam int NUM_PIXELS_DEF = 5;
  localparam int MAX_LOADS_DEF  = 255;
  localparam int TIMEOUT_DEF    = 1024;

  localparam logic [1:0] COLOR_GREEN = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_REQ,
    SENDING
  } arb_state_t;

  // Only G, R and B exist; the fourth encoding is rejected.
  function automatic logic color_valid(input logic [1:0] c);
    return (c == COLOR_GREEN) || (c == COLOR_RED) || (c == COLOR_BLUE);
  endfunction

endpackage

// File: rtl/neo_counter.sv
// Generic saturating up-counter.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clr          : synchronous clear (wins over inc)
//   inc          : count up by one, holding at MAX
//   count        : current value
module neo_counter #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/neo_rr_pick2.sv
// Combinational two-way round-robin chooser.
// Ports:
//   req    : request vector
//   rr_ptr : index favoured when both request
//   winner : one-hot winner (00 when nobody requests)
module neo_rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/neo_frame_arbiter.sv
// Shares one NeoPixel driver load/send port between two frame producers.
// A grant covers exactly one frame: forwarded loads, one send, then the
// driver's latch delay. Priority alternates round-robin, and a watchdog
// revokes the grant from an owner that stalls in the load phase.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   req[1:0]                      : frame requests, held until frame_done/abort
//   req_load, req_send            : per-requester load / send strobes
//   req_pixel_index/color_index/color_level : packed {req1, req0} load fields
//   ready_to_load, ready_to_send, done_wait : driver handshake
//   grant                         : one-hot owner, 00 when idle
//   load_color, pixel_index, color_index, color_level : forwarded load
//   send_it                       : single-cycle send strobe
//   frame_done, abort             : 1-cycle pulses to the owner
//   load_err                      : 1-cycle pulse for a dropped load
module neo_frame_arbiter
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int MAX_LOADS  = MAX_LOADS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_load,
  input  logic [5:0]  req_pixel_index,
  input  logic [3:0]  req_color_index,
  input  logic [15:0] req_color_level,
  input  logic [1:0]  req_send,
  input  logic        ready_to_load,
  input  logic        ready_to_send,
  input  logic        done_wait,
  output logic [1:0]  grant,
  output logic        load_color,
  output logic [2:0]  pixel_index,
  output logic [1:0]  color_index,
  output logic [7:0]  color_level,
  output logic        send_it,
  output logic [1:0]  frame_done,
  output logic [1:0]  abort,
  output logic        load_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t      state, state_next;
  logic [1:0]      grant_next;
  logic            rr_ptr, rr_next;
  logic [1:0]      winner;
  logic [7:0]      load_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_clr;

  // Owner index; only meaningful while grant is non-zero.
  logic       owner;
  logic [2:0] own_pix;
  logic [1:0] own_col;
  logic [7:0] own_lvl;
  logic       own_req, own_load, own_send;
  logic       index_ok, cnt_full, wd_expired;

  assign owner    = grant[1];
  assign own_pix  = owner ? req_pixel_index[5:3]  : req_pixel_index[2:0];
  assign own_col  = owner ? req_color_index[3:2]  : req_color_index[1:0];
  assign own_lvl  = owner ? req_color_level[15:8] : req_color_level[7:0];
  assign own_req  = req[owner];
  assign own_load = req_load[owner];
  assign own_send = req_send[owner];

  assign index_ok   = (int'(own_pix) < NUM_PIXELS) && color_valid(own_col);
  assign cnt_full   = (int'(load_cnt) >= MAX_LOADS);
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT));

  neo_rr_pick2 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_next     = rr_ptr;
    load_color  = 1'b0;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    send_it     = 1'b0;
    frame_done  = 2'b00;
    abort       = 2'b00;
    load_err    = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_next = winner;
          state_next = LOAD;
        end
      end

      LOAD: begin
        // A bad index or exhausted budget drops the load even while the
        // driver is busy; a merely stalled load is held by the requester.
        if (own_load) begin
          if (index_ok && !cnt_full) begin
            if (ready_to_load) begin
              load_color  = 1'b1;
              pixel_index = own_pix;
              color_index = own_col;
              color_level = own_lvl;
            end
          end else begin
            load_err = 1'b1;
          end
        end
        if (!own_req || wd_expired) begin
          abort      = grant;
          grant_next = 2'b00;
          rr_next    = ~owner;
          state_next = IDLE;
        end else if (own_send) begin
          state_next = SEND_REQ;
        end
      end

      SEND_REQ: begin
        if (!own_req) begin
          abort      = grant;
          grant_next = 2'b00;
          rr_next    = ~owner;
          state_next = IDLE;
        end else if (ready_to_send) begin
          send_it    = 1'b1;
          state_next = SENDING;
        end
      end

      SENDING: begin
        // The frame is committed; requester lines are ignored here.
        if (done_wait) begin
          frame_done = grant;
          grant_next = 2'b00;
          rr_next    = ~owner;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= 2'b00;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_next;
    end
  end

  // Load budget restarts with every grant.
  neo_counter #(.W(8), .MAX(MAX_LOADS)) u_load_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (state == IDLE),
    .inc   (load_color),
    .count (load_cnt)
  );

  // Watchdog counts idle LOAD cycles; any owner activity or state change
  // restarts it.
  assign wd_clr = (state != LOAD) || (state_next != state) || own_load || own_send;

  neo_counter #(.W(WD_W), .MAX(TIMEOUT)) u_wd_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (wd_clr),
    .inc   (1'b1),
    .count (wd_cnt)
  );

endmodule

// File: tb/tb_neo_frame_arbiter.sv
module tb_neo_frame_arbiter;

  localparam int NP = 5;
  localparam int ML = 255;
  localparam int TO = 16;

  logic        clock;
  logic        reset;
  logic [1:0]  req, req_load, req_send;
  logic [5:0]  req_pixel_index;
  logic [3:0]  req_color_index;
  logic [15:0] req_color_level;
  logic        ready_to_load, ready_to_send, done_wait;
  logic [1:0]  grant;
  logic        load_color;
  logic [2:0]  pixel_index;
  logic [1:0]  color_index;
  logic [7:0]  color_level;
  logic        send_it;
  logic [1:0]  frame_done, abort;
  logic        load_err;

  neo_frame_arbiter #(.NUM_PIXELS(NP), .MAX_LOADS(ML), .TIMEOUT(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .req_load        (req_load),
    .req_pixel_index (req_pixel_index),
    .req_color_index (req_color_index),
    .req_color_level (req_color_level),
    .req_send        (req_send),
    .ready_to_load   (ready_to_load),
    .ready_to_send   (ready_to_send),
    .done_wait       (done_wait),
    .grant           (grant),
    .load_color      (load_color),
    .pixel_index     (pixel_index),
    .color_index     (color_index),
    .color_level     (color_level),
    .send_it         (send_it),
    .frame_done      (frame_done),
    .abort           (abort),
    .load_err        (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Staged stimulus, applied just after each rising edge.
  logic       s_reset, s_rtl, s_rts, s_dw;
  logic [1:0] s_req, s_req_load, s_req_send;
  int         s_pix[2];
  int         s_col[2];
  logic [7:0] s_lvl[2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] grant;
    logic       lc;
    int         pix;
    int         col;
    int         lvl;
    logic       snd;
    logic [1:0] fd;
    logic [1:0] ab;
    logic       err;
  } ev_t;

  ev_t expq[$];

  // Reference model: who owns the driver and which part of the frame it is in.
  int         m_owner = -1;    // -1: nobody
  int         m_phase = 0;     // 0 loading, 1 waiting to send, 2 sending
  int         m_loads = 0;
  int         m_idle  = 0;
  int         m_rr    = 0;
  logic [1:0] m_prev_grant = 2'b00;

  int n_lc = 0, n_err = 0, n_snd = 0, n_fd = 0, n_ab = 0;

  task automatic check(input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  task automatic chk_val(input string name, input int act, input int exp);
    check(act == exp, $sformatf("%s actual=%0d required=%0d", name, act, exp));
  endtask

  function automatic void model_step();
    ev_t e;
    int  o;
    bit  ok, full;
    e = '{default: 0};
    e.cyc   = cyc;
    e.grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    if (m_owner < 0) begin
      if (s_req != 2'b00) begin
        m_owner = (s_req == 2'b11) ? m_rr : (s_req[1] ? 1 : 0);
        m_phase = 0;
        m_loads = 0;
        m_idle  = 0;
      end
    end else begin
      o = m_owner;
      if (m_phase == 0) begin
        ok   = (s_pix[o] < NP) && (s_col[o] != 3);
        full = (m_loads >= ML);
        if (s_req_load[o]) begin
          if (!ok || full) e.err = 1'b1;
          else if (s_rtl) begin
            e.lc  = 1'b1;
            e.pix = s_pix[o];
            e.col = s_col[o];
            e.lvl = int'(s_lvl[o]);
            m_loads++;
          end
        end
        if (!s_req[o] || m_idle == TO) begin
          e.ab = 2'(1 << o); m_owner = -1; m_rr = 1 - o;
        end else if (s_req_send[o]) begin
          m_phase = 1; m_idle = 0;
        end else if (s_req_load[o]) m_idle = 0;
        else m_idle++;
      end else if (m_phase == 1) begin
        if (!s_req[o]) begin
          e.ab = 2'(1 << o); m_owner = -1; m_rr = 1 - o;
        end else if (s_rts) begin
          e.snd = 1'b1; m_phase = 2;
        end
      end else begin
        if (s_dw) begin
          e.fd = 2'(1 << o); m_owner = -1; m_rr = 1 - o;
        end
      end
    end
    if (s_reset) begin
      m_owner = -1;
      m_rr    = 0;
    end
    if (e.lc || e.snd || e.fd != 0 || e.ab != 0 || e.err || e.grant != m_prev_grant)
      expq.push_back(e);
    m_prev_grant = e.grant;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    reset           = s_reset;
    req             = s_req;
    req_load        = s_req_load;
    req_send        = s_req_send;
    req_pixel_index = {3'(s_pix[1]), 3'(s_pix[0])};
    req_color_index = {2'(s_col[1]), 2'(s_col[0])};
    req_color_level = {s_lvl[1], s_lvl[0]};
    ready_to_load   = s_rtl;
    ready_to_send   = s_rts;
    done_wait       = s_dw;
    cyc++;
    model_step();
    mon_en = 1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  // Monitor: whenever the DUT presents a strobe or a grant change, pop and compare.
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clock) begin
    if (mon_en) begin
      bit  present;
      ev_t e;
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        check(0, $sformatf("missing_event cyc=%0d actual=none required g=%b lc=%b snd=%b fd=%b ab=%b err=%b",
                           e.cyc, e.grant, e.lc, e.snd, e.fd, e.ab, e.err));
      end
      present = load_color || send_it || frame_done != 0 || abort != 0 || load_err ||
                grant != prev_grant;
      if (present) begin
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
          e = expq.pop_front();
          check(grant == e.grant && load_color == e.lc && int'(pixel_index) == e.pix &&
                int'(color_index) == e.col && int'(color_level) == e.lvl &&
                send_it == e.snd && frame_done == e.fd && abort == e.ab && load_err == e.err,
                $sformatf("event cyc=%0d actual{g=%b lc=%b p=%0d c=%0d l=%0d s=%b fd=%b ab=%b e=%b} required{g=%b lc=%b p=%0d c=%0d l=%0d s=%b fd=%b ab=%b e=%b}",
                          cyc, grant, load_color, pixel_index, color_index, color_level,
                          send_it, frame_done, abort, load_err,
                          e.grant, e.lc, e.pix, e.col, e.lvl, e.snd, e.fd, e.ab, e.err));
        end else begin
          check(0, $sformatf("unexpected_event cyc=%0d actual{g=%b lc=%b s=%b fd=%b ab=%b e=%b} required=none",
                             cyc, grant, load_color, send_it, frame_done, abort, load_err));
        end
      end
      n_lc  += int'(load_color);
      n_err += int'(load_err);
      n_snd += int'(send_it);
      n_fd  += int'(frame_done != 0);
      n_ab  += int'(abort != 0);
      prev_grant = grant;
    end
  end

  task automatic clear_stim();
    s_req_load = 2'b00; s_req_send = 2'b00;
    s_rtl = 1'b1; s_rts = 1'b0; s_dw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_pix[i] = 0; s_col[i] = 0; s_lvl[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    clear_stim();
    s_req   = 2'b00;
    s_reset = 1'b1;
    tick();
    tick();
    s_reset = 1'b0;
  endtask

  // Random activity on the non-owner's load/send lines, which must be ignored.
  task automatic noise(input int who);
    int other;
    other = 1 - who;
    s_req_load[other] = 1'($urandom % 2);
    s_req_send[other] = 1'($urandom % 2);
    s_pix[other] = $urandom % 8;
    s_col[other] = $urandom % 4;
    s_lvl[other] = 8'($urandom);
  endtask

  task automatic do_loads(input int who, input int n, input bit walk);
    for (int k = 0; k < n; k++) begin
      noise(who);
      s_req_load[who] = 1'b1;
      s_req_send[who] = 1'b0;
      s_pix[who] = walk ? (k / 3) % NP : $urandom % NP;
      s_col[who] = walk ? k % 3 : $urandom % 3;
      s_lvl[who] = 8'($urandom);
      s_rtl = 1'b1;
      tick();
    end
    s_req_load = 2'b00;
    s_req_send = 2'b00;
  endtask

  task automatic send_and_finish(input int who);
    s_req_send[who] = 1'b1; s_rts = 1'b0; tick();
    s_req_send = 2'b00;     tick();
    s_rts = 1'b1;           tick();
    s_rts = 1'b0;           tick();
    s_dw  = 1'b1;           tick();
    s_dw  = 1'b0;
  endtask

  initial begin
    int b_lc, b_err, b_snd, b_fd, b_ab;
    reset = 1'b1; req = 0; req_load = 0; req_send = 0;
    req_pixel_index = 0; req_color_index = 0; req_color_level = 0;
    ready_to_load = 0; ready_to_send = 0; done_wait = 0;

    // Reset state
    do_reset();
    #1;
    chk_val("rst_grant", grant, 0);
    chk_val("rst_load_color", load_color, 0);
    chk_val("rst_send_it", send_it, 0);
    chk_val("rst_frame_done", frame_done, 0);
    chk_val("rst_abort", abort, 0);
    chk_val("rst_load_err", load_err, 0);
    chk_val("rst_pixel_index", pixel_index, 0);
    chk_val("rst_color_level", color_level, 0);

    // Single owner: 15 walking loads, one send, one frame_done
    s_req = 2'b01; tick();
    settle(); b_lc = n_lc; b_snd = n_snd; b_fd = n_fd;
    do_loads(0, 15, 1);
    send_and_finish(0);
    s_req = 2'b00; tick();
    settle();
    chk_val("single_loads", n_lc - b_lc, 15);
    chk_val("single_sends", n_snd - b_snd, 1);
    chk_val("single_done", n_fd - b_fd, 1);
    chk_val("single_grant_after", grant, 0);

    // Contention: 01, then idle gap, then 10, then 01 again
    do_reset();
    s_req = 2'b11; tick();
    #1; chk_val("cont_idle0", grant, 0);
    do_loads(0, 3, 0);
    send_and_finish(0);
    s_req = 2'b10; tick();
    #1; chk_val("cont_gap", grant, 0);
    tick();
    #1; chk_val("cont_second", grant, 2);
    do_loads(1, 2, 0);
    send_and_finish(1);
    s_req = 2'b11; tick();
    #1; chk_val("cont_gap2", grant, 0);
    tick();
    #1; chk_val("cont_third", grant, 1);
    do_loads(0, 1, 0);
    send_and_finish(0);
    s_req = 2'b00; tick(); tick();

    // Bad loads: bad pixel, bad color, then 256 valid loads
    do_reset();
    s_req = 2'b01; tick();
    settle(); b_lc = n_lc; b_err = n_err; b_ab = n_ab;
    s_req_load = 2'b01; s_pix[0] = NP; s_col[0] = 0; tick();
    s_pix[0] = 0; s_col[0] = 3; tick();
    do_loads(0, 256, 0);
    s_req = 2'b00; tick(); tick();
    settle();
    chk_val("bad_load_count", n_lc - b_lc, ML);
    chk_val("bad_err_count", n_err - b_err, 3);
    chk_val("bad_abort_count", n_ab - b_ab, 1);

    // Watchdog: TO idle cycles allowed, revoked on the next one
    do_reset();
    s_req = 2'b11; tick();
    settle(); b_snd = n_snd; b_ab = n_ab;
    for (int k = 0; k < TO; k++) begin
      noise(0); s_req_load[0] = 1'b0; s_req_send[0] = 1'b0; tick();
    end
    #1; chk_val("wd_no_abort_yet", abort, 0);
    s_req_load = 2'b00; s_req_send = 2'b00; tick();
    #1; chk_val("wd_abort", abort, 1);
    tick();
    #1; chk_val("wd_gap", grant, 0);
    tick();
    #1; chk_val("wd_next_owner", grant, 2);
    s_req = 2'b00; tick(); tick();
    settle();
    chk_val("wd_no_send", n_snd - b_snd, 0);
    chk_val("wd_aborts", n_ab - b_ab, 2);

    // Backpressure: stalled load is held without error
    do_reset();
    s_req = 2'b01; tick();
    settle(); b_lc = n_lc; b_err = n_err;
    s_req_load = 2'b01; s_pix[0] = 4; s_col[0] = 2; s_lvl[0] = 8'($urandom); s_rtl = 1'b0;
    repeat (5) tick();
    s_rtl = 1'b1; tick();
    s_req_load = 2'b00; tick();
    settle();
    chk_val("bp_loads", n_lc - b_lc, 1);
    chk_val("bp_errs", n_err - b_err, 0);
    send_and_finish(0);
    s_req = 2'b00; tick();

    // Reset while SENDING
    do_reset();
    s_req = 2'b01; tick();
    do_loads(0, 2, 0);
    s_req_send = 2'b01; tick();
    s_req_send = 2'b00; s_rts = 1'b1; tick();
    s_rts = 1'b0; tick();
    s_reset = 1'b1; s_req = 2'b00; tick();
    s_reset = 1'b0; tick();
    #1;
    chk_val("rs_grant", grant, 0);
    chk_val("rs_frame_done", frame_done, 0);
    chk_val("rs_send_it", send_it, 0);
    s_dw = 1'b1; tick();
    #1; chk_val("rs_late_done", frame_done, 0);
    s_dw = 1'b0; tick();

    // Random soak against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom % 12 == 0) s_req[i] = ~s_req[i];
        s_req_load[i] = 1'($urandom % 3 == 0);
        s_req_send[i] = 1'($urandom % 20 == 0);
        s_pix[i] = $urandom % 8;
        s_col[i] = $urandom % 4;
        s_lvl[i] = 8'($urandom);
      end
      s_rtl = 1'($urandom % 4 != 0);
      s_rts = 1'($urandom % 3 == 0);
      s_dw  = 1'($urandom % 4 == 0);
      tick();
    end

    clear_stim();
    s_req = 2'b00;
    repeat (20) tick();
    settle();
    chk_val("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
